// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int CLA_BLOCK_DEFAULT = 8;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Combine a more-significant generate/propagate pair with a less-significant one.
    function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/cla_gp_block.sv
// Combinational N-bit lookahead window: internal carries into bits 1..N-1 plus group g/p.
module cla_gp_block
    import cla_pkg::*;
#(
    parameter int N = CLA_BLOCK_DEFAULT
)(
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-2:0] o_carry,
    output logic         o_g,
    output logic         o_p
);

    gp_t [N-1:0] w_pre;

    // Prefix g/p over bits 0..i; independent of carry-in so group g/p never waits on it.
    always_comb begin
        w_pre[0] = gp_t'{g: i_a[0] & i_b[0], p: i_a[0] | i_b[0]};
        for (int i = 1; i < N; i++) begin
            w_pre[i] = gp_merge(gp_t'{g: i_a[i] & i_b[i], p: i_a[i] | i_b[i]}, w_pre[i-1]);
        end
    end

    // Carry into bit i+1 resolved directly from the prefix and the window carry-in.
    always_comb begin
        o_carry = {(N-1){1'b0}};
        for (int i = 0; i < N-1; i++) begin
            o_carry[i] = w_pre[i].g | (w_pre[i].p & i_cin);
        end
    end

    assign o_g = w_pre[N-1].g;
    assign o_p = w_pre[N-1].p;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined, elastic carry-lookahead adder/subtractor with status flags.
// Optional signed saturation (in_sat port) is enabled by defining CLA_PIPE_SAT_EN.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = CLA_BLOCK_DEFAULT,
    parameter int STAGES = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
`ifdef CLA_PIPE_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NWIN = WIDTH / BLOCK;
    localparam int K    = NWIN / STAGES;
    localparam int SW   = K * BLOCK;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]            r_v;
    logic [STAGES-1:0][WIDTH-1:0] r_a;
    logic [STAGES-1:0][WIDTH-1:0] r_b;
    logic [STAGES-1:0][WIDTH-1:0] r_psum;
    logic [STAGES-1:0]            r_c;

    logic [STAGES-1:0]            w_load;
    logic [STAGES-1:0]            w_vin;
    logic [STAGES-1:0][WIDTH-1:0] w_a_in;
    logic [STAGES-1:0][WIDTH-1:0] w_b_in;
    logic [STAGES-1:0][WIDTH-1:0] w_psum_in;
    logic [STAGES-1:0][WIDTH-1:0] w_sum_nxt;
    logic [STAGES-1:0]            w_c_in;
    logic [STAGES-1:0]            w_c_nxt;

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_fin;
    logic             w_cout;
    logic             w_ovf;
    op_e              w_op;

`ifdef CLA_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [STAGES-1:0] r_sat;
    logic [STAGES-1:0] w_sat_in;
`endif

    assign w_op = op_e'(in_sub);

    // A stage can load when some stage at or after it is empty, or the output is draining.
    always_comb begin
        logic w_full;
        w_full = 1'b1;
        w_load = {STAGES{1'b0}};
        for (int s = LAST; s >= 0; s--) begin
            w_full    = w_full & r_v[s];
            w_load[s] = ~w_full | out_ready;
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v[LAST];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [K-1:0]  w_g;
        logic [K-1:0]  w_p;
        logic [K:0]    w_wc;
        logic [SW-1:0] w_win_sum;

        if (s == 0) begin : g_src_in
            assign w_vin[0]     = in_valid;
            assign w_a_in[0]    = in_a;
            assign w_b_in[0]    = (w_op == OP_SUB) ? ~in_b : in_b;
            assign w_c_in[0]    = (w_op == OP_SUB) ? 1'b1 : in_cin;
            assign w_psum_in[0] = {WIDTH{1'b0}};
`ifdef CLA_PIPE_SAT_EN
            assign w_sat_in[0]  = in_sat;
`endif
        end else begin : g_src_reg
            assign w_vin[s]     = r_v[s-1];
            assign w_a_in[s]    = r_a[s-1];
            assign w_b_in[s]    = r_b[s-1];
            assign w_c_in[s]    = r_c[s-1];
            assign w_psum_in[s] = r_psum[s-1];
`ifdef CLA_PIPE_SAT_EN
            assign w_sat_in[s]  = r_sat[s-1];
`endif
        end

        for (genvar k = 0; k < K; k++) begin : g_win
            localparam int LO = s * SW + k * BLOCK;
            logic [BLOCK-2:0] w_ic;

            cla_gp_block #(.N(BLOCK)) u_blk (
                .i_a     (w_a_in[s][LO +: BLOCK]),
                .i_b     (w_b_in[s][LO +: BLOCK]),
                .i_cin   (w_wc[k]),
                .o_carry (w_ic),
                .o_g     (w_g[k]),
                .o_p     (w_p[k])
            );

            assign w_win_sum[k*BLOCK +: BLOCK] =
                w_a_in[s][LO +: BLOCK] ^ w_b_in[s][LO +: BLOCK] ^ {w_ic, w_wc[k]};
        end

        // Window carries come from a prefix over the stage's windows rather than rippling.
        always_comb begin
            gp_t w_acc;
            w_acc   = gp_t'{g: 1'b0, p: 1'b1};
            w_wc    = {(K+1){1'b0}};
            w_wc[0] = w_c_in[s];
            for (int k = 0; k < K; k++) begin
                w_acc     = gp_merge(gp_t'{g: w_g[k], p: w_p[k]}, w_acc);
                w_wc[k+1] = w_acc.g | (w_acc.p & w_wc[0]);
            end
        end

        // Bits above this stage are still zero in the carried partial sum.
        assign w_sum_nxt[s] = w_psum_in[s] | (WIDTH'(w_win_sum) << (s * SW));
        assign w_c_nxt[s]   = w_wc[K];
    end

    assign w_raw  = w_sum_nxt[LAST];
    assign w_cout = w_c_nxt[LAST];
    assign w_ovf  = w_cout ^ (w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1] ^ w_raw[WIDTH-1]);

`ifdef CLA_PIPE_SAT_EN
    // Clamp toward the sign of A when the beat asked for saturation and overflowed.
    always_comb begin
        if (w_sat_in[LAST] & w_ovf) begin
            w_fin = w_a_in[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            w_fin = w_raw;
        end
    end
`else
    assign w_fin = w_raw;
`endif

    // Pipeline stage registers; the last stage is the output register set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v      <= {STAGES{1'b0}};
            r_a      <= '0;
            r_b      <= '0;
            r_psum   <= '0;
            r_c      <= {STAGES{1'b0}};
`ifdef CLA_PIPE_SAT_EN
            r_sat    <= {STAGES{1'b0}};
`endif
            out_sum  <= {WIDTH{1'b0}};
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_load[s]) begin
                    r_v[s] <= w_vin[s];
                end
            end
            for (int s = 0; s < LAST; s++) begin
                if (w_load[s] & w_vin[s]) begin
                    r_a[s]    <= w_a_in[s];
                    r_b[s]    <= w_b_in[s];
                    r_psum[s] <= w_sum_nxt[s];
                    r_c[s]    <= w_c_nxt[s];
`ifdef CLA_PIPE_SAT_EN
                    r_sat[s]  <= w_sat_in[s];
`endif
                end
            end
            if (w_load[LAST] & w_vin[LAST]) begin
                out_sum  <= w_fin;
                out_cout <= w_cout;
                out_ovf  <= w_ovf;
                out_zero <= (w_fin == {WIDTH{1'b0}});
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub: arithmetic reference model plus scoreboard.
module tb_cla_pipe_addsub;

    localparam int W   = 32;
    localparam int BLK = 8;
    localparam int STG = 2;
`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_cin, in_sub, in_sat;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [W-1:0] out_sum;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    res_t   exp_q[$];
    res_t   mon_e;
    res_t   pm;
    int     n_chk = 0;
    int     n_pass = 0;
    int     n_ret = 0;
    int     ret0;
    logic   rdy_rand = 1'b0;
    logic   rdy_val = 1'b1;
    logic [W-1:0] sp [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(W), .BLOCK(BLK), .STAGES(STG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
`ifdef CLA_PIPE_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic sat);
        logic [W-1:0] bb;
        logic [W:0]   full;
        res_t         r;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
        if (sat && r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        r.zero = (r.sum == {W{1'b0}});
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 4) == 0) return sp[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    // Drive one beat from the posedge+1 phase; return just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic sat);
        logic acc;
        acc = 1'b0;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_sat = sat & SAT_EN;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic expect_result(input string name, input res_t e);
        @(negedge clk);
        chk({name, "_early"}, out_valid, 1'b0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_sum"}, out_sum, e.sum);
        chk({name, "_cout"}, out_cout, e.cout);
        chk({name, "_ovf"}, out_ovf, e.ovf);
        chk({name, "_zero"}, out_zero, e.zero);
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    // Scoreboard: every valid output cycle must match the oldest outstanding beat.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_spurious", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q[0];
                    chk("sb_sum", out_sum, mon_e.sum);
                    chk("sb_cout", out_cout, mon_e.cout);
                    chk("sb_ovf", out_ovf, mon_e.ovf);
                    chk("sb_zero", out_zero, mon_e.zero);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_ret++;
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub, SAT_EN & in_sat));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; in_sat = 1'b0;

        pm = model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        chk("pin_add_wrap", pm, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
        pm = model(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        chk("pin_sub_ovf", pm, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        pm = model(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 1'b0);
        chk("pin_sub_borrow", pm, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_flags", {out_cout, out_ovf, out_zero}, 3'b000);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        expect_result("t1", {32'h0000_0000, 1'b1, 1'b0, 1'b1});
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        expect_result("t2", {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        expect_result("t2b", {32'h2345_678A, 1'b0, 1'b0, 1'b0});

        // Back-pressure: four beats, downstream stalled until the pipe is full.
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        ret0 = n_ret;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(32'h1000_0001 * (i + 1), 32'h0000_0100, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                chk("t3_in_ready_full", in_ready, 1'b0);
                chk("t3_out_held", out_valid, 1'b1);
                rdy_val = 1'b1;
                @(negedge clk);
                chk("t3_in_ready_release", in_ready, 1'b1);
            end
        join
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_retired", n_ret - ret0, 4);

        // Reset with two beats in flight drops them.
        send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
        send(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_out_valid", out_valid, 1'b0);
        chk("t4_out_sum", out_sum, 32'h0);
        chk("t4_out_flags", {out_cout, out_ovf, out_zero}, 3'b000);
        chk("t4_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        send(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0);
        expect_result("t4_new", {32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0});

`ifdef CLA_PIPE_SAT_EN
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        expect_result("t5_sat", {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        expect_result("t5_wrap", {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        expect_result("t5_sat_neg", {32'h8000_0000, 1'b1, 1'b1, 1'b0});
`endif

        // Random beats with random source gaps and sink stalls.
        ret0 = n_ret;
        rdy_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        rdy_rand = 1'b0;
        rdy_val = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_retired", n_ret - ret0, 3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
